// File: rtl/collision_scheduler.sv
// collision_scheduler: walks every unordered object pair through the external collision detector once per
// frame, building a per-object hit mask and hit count. Define COLLISION_HIT_STREAM_EN to stream hit pairs.
module collision_scheduler #(
  parameter int N_OBJ = 8,
  parameter int IDX_W = $clog2(N_OBJ),
  parameter int CNT_W = $clog2(N_OBJ * (N_OBJ - 1) / 2 + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [N_OBJ-1:0] obj_active,
  output logic [IDX_W-1:0] sel_a,
  output logic [IDX_W-1:0] sel_b,
  input  logic             is_collision,
  output logic             busy,
  output logic             done,
  output logic [N_OBJ-1:0] collide_mask,
  output logic [CNT_W-1:0] hit_count,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [IDX_W-1:0] hit_a,
  output logic [IDX_W-1:0] hit_b
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_A = IDX_W'(N_OBJ - 2);
  localparam logic [IDX_W-1:0] LAST_B = IDX_W'(N_OBJ - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   sel_a_q, sel_b_q;
  logic [IDX_W-1:0]   sel_a_d, sel_b_d;
  logic               busy_q, done_q;
  logic [N_OBJ-1:0]   collide_mask_q;
  logic [CNT_W-1:0]   hit_count_q;

  logic               capture;
  logic               pair_hit;
  logic               last_pair;
  logic [N_OBJ-1:0]   pair_mask;

`ifdef COLLISION_HIT_STREAM_EN
  logic               hit_valid_q;
  logic [IDX_W-1:0]   hit_a_q, hit_b_q;

  // A presented hit that the consumer refuses freezes the pair walk.
  assign capture = !(hit_valid_q && !hit_ready);
`else
  logic               unused_hit_ready;

  assign unused_hit_ready = hit_ready;
  assign capture          = 1'b1;
`endif

  assign pair_hit  = is_collision && obj_active[sel_a_q] && obj_active[sel_b_q];
  assign last_pair = (sel_a_q == LAST_A) && (sel_b_q == LAST_B);
  assign pair_mask = (N_OBJ'(1) << sel_a_q) | (N_OBJ'(1) << sel_b_q);

  // NOTE: every variable gets a default before the branch so no latch is inferred.
  always_comb begin
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q + IDX_W'(1);
    if (sel_b_q == LAST_B) begin
      sel_a_d = sel_a_q + IDX_W'(1);
      sel_b_d = sel_a_q + IDX_W'(2);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= ST_IDLE;
      sel_a_q        <= '0;
      sel_b_q        <= IDX_W'(1);
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      collide_mask_q <= '0;
      hit_count_q    <= '0;
`ifdef COLLISION_HIT_STREAM_EN
      hit_valid_q    <= 1'b0;
      hit_a_q        <= '0;
      hit_b_q        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef COLLISION_HIT_STREAM_EN
      if (hit_valid_q && hit_ready) begin
        hit_valid_q <= 1'b0;
      end
`endif
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q        <= ST_SCAN;
            busy_q         <= 1'b1;
            sel_a_q        <= '0;
            sel_b_q        <= IDX_W'(1);
            collide_mask_q <= '0;
            hit_count_q    <= '0;
          end
        end
        ST_SCAN: begin
          if (capture) begin
            if (pair_hit) begin
              collide_mask_q <= collide_mask_q | pair_mask;
              hit_count_q    <= hit_count_q + CNT_W'(1);
`ifdef COLLISION_HIT_STREAM_EN
              // Overrides the acceptance clear above, giving back-to-back hits.
              hit_valid_q    <= 1'b1;
              hit_a_q        <= sel_a_q;
              hit_b_q        <= sel_b_q;
`endif
            end
            if (last_pair) begin
              state_q <= ST_DRAIN;
            end else begin
              sel_a_q <= sel_a_d;
              sel_b_q <= sel_b_d;
            end
          end
        end
        ST_DRAIN: begin
          if (capture) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel_a        = sel_a_q;
  assign sel_b        = sel_b_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign collide_mask = collide_mask_q;
  assign hit_count    = hit_count_q;

`ifdef COLLISION_HIT_STREAM_EN
  assign hit_valid = hit_valid_q;
  assign hit_a     = hit_a_q;
  assign hit_b     = hit_b_q;
`else
  assign hit_valid = 1'b0;
  assign hit_a     = '0;
  assign hit_b     = '0;
`endif

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: a pair-table detector model, queues of expected sel pairs,
// hits and scan results, and a negedge monitor that pops and compares them.
`timescale 1ns/1ps
module tb_collision_scheduler;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int CW = 5;
  localparam int P  = N * (N - 1) / 2;
`ifdef COLLISION_HIT_STREAM_EN
  localparam bit STREAM = 1'b1;
`else
  localparam bit STREAM = 1'b0;
`endif

  typedef struct {
    int a;
    int b;
  } pair_t;

  typedef struct {
    int         cyc;
    logic [N-1:0] mask;
    int         count;
  } done_t;

  logic          Clk        = 1'b0;
  logic          Reset_n    = 1'b0;
  logic          start      = 1'b0;
  logic [N-1:0]  obj_active = '0;
  logic          hit_ready  = 1'b1;
  logic [IW-1:0] sel_a, sel_b, hit_a, hit_b;
  logic          is_collision, busy, done, hit_valid;
  logic [N-1:0]  collide_mask;
  logic [CW-1:0] hit_count;

  logic [N-1:0]  coll_tab [N];
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;
  pair_t         pair_q [$];
  pair_t         hit_q  [$];
  done_t         done_q [$];
  pair_t         mp;
  done_t         md;

  collision_scheduler #(.N_OBJ(N), .IDX_W(IW), .CNT_W(CW)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .obj_active   (obj_active),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .is_collision (is_collision),
    .busy         (busy),
    .done         (done),
    .collide_mask (collide_mask),
    .hit_count    (hit_count),
    .hit_valid    (hit_valid),
    .hit_ready    (hit_ready),
    .hit_a        (hit_a),
    .hit_b        (hit_b)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Model detector: pair (a,b) collides when its table bit is set.
  assign is_collision = coll_tab[sel_a][sel_b];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sel_a"}, sel_a, 0);
    check({tag, "_sel_b"}, sel_b, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mask"}, collide_mask, 0);
    check({tag, "_count"}, hit_count, 0);
    check({tag, "_hit_valid"}, hit_valid, 0);
    check({tag, "_hit_a"}, hit_a, 0);
    check({tag, "_hit_b"}, hit_b, 0);
  endtask

  // Monitor: compares DUT activity against the queued expectations.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (busy && !(hit_valid && !hit_ready) && pair_q.size() > 0) begin
        mp = pair_q.pop_front();
        check("sel_a", sel_a, mp.a);
        check("sel_b", sel_b, mp.b);
      end
      if (hit_valid && hit_ready) begin
        if (hit_q.size() == 0) begin
          check("unexpected_hit", 1, 0);
        end else begin
          mp = hit_q.pop_front();
          check("hit_a", hit_a, mp.a);
          check("hit_b", hit_b, mp.b);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          md = done_q.pop_front();
          if (md.cyc >= 0) check("done_cycle", cyc, md.cyc);
          check("done_mask", collide_mask, md.mask);
          check("done_count", hit_count, md.count);
          check("busy_at_done", busy, 0);
          check("hits_left_at_done", hit_q.size(), 0);
        end
      end
    end
  end

  // Caller must be at posedge+1. Offsets are cycles relative to cycle 0 of the scan (-1 = unused).
  task automatic run_scan(input logic [N-1:0] act, input bit rand_ready, input int stall_at,
                          input int stall_len, input int restart_at, input int reset_at);
    logic [N-1:0] m   = '0;
    int           cnt = 0;
    int           t0;
    int           idx;
    bit           ended = 1'b0;
    pair_t        p;
    pair_t        pl[$];
    done_t        d;

    obj_active = act;
    hit_ready  = 1'b1;
    start      = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    t0    = cyc;

    for (int a = 0; a < N - 1; a++) begin
      for (int b = a + 1; b < N; b++) begin
        p.a = a;
        p.b = b;
        pl.push_back(p);
        pair_q.push_back(p);
        if (coll_tab[a][b] && act[a] && act[b]) begin
          m[a] = 1'b1;
          m[b] = 1'b1;
          cnt++;
          if (STREAM) hit_q.push_back(p);
        end
      end
    end
    d.cyc   = rand_ready ? -1 : t0 + P + 1 + (STREAM ? stall_len : 0);
    d.mask  = m;
    d.count = cnt;
    done_q.push_back(d);

    for (int c = 1; c <= 400; c++) begin
      @(posedge Clk);
      #1;
      if (rand_ready) hit_ready = 1'($urandom_range(0, 1));
      else            hit_ready = !(c >= stall_at && c < stall_at + stall_len);
      start = (c == restart_at);
      if (c == reset_at) begin
        Reset_n = 1'b0;
        #1;
        check_reset_vals("midscan_reset");
        pair_q.delete();
        hit_q.delete();
        done_q.delete();
        repeat (2) @(posedge Clk);
        #1;
        start     = 1'b0;
        hit_ready = 1'b1;
        Reset_n   = 1'b1;
        return;
      end
      if (stall_len > 0 && c == stall_at + 2) begin
        idx = STREAM ? stall_at : stall_at + 2;
        check("stall_sel_a", sel_a, pl[idx].a);
        check("stall_sel_b", sel_b, pl[idx].b);
      end
      if (done_q.size() == 0) begin
        ended = 1'b1;
        break;
      end
    end
    start     = 1'b0;
    hit_ready = 1'b1;

    if (!ended) begin
      check("done_timeout", 0, 1);
      pair_q.delete();
      hit_q.delete();
      done_q.delete();
    end

    @(negedge Clk);
    check("busy_after_done", busy, 0);
    repeat (3) @(posedge Clk);
    #1;
    check("hold_mask", collide_mask, m);
    check("hold_count", hit_count, cnt);
  endtask

  task automatic clear_tab();
    for (int i = 0; i < N; i++) coll_tab[i] = '0;
  endtask

  int quiet;

  initial begin
    clear_tab();
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_vals("in_reset");
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    check_reset_vals("after_reset");

    quiet = 0;
    repeat (50) begin
      @(negedge Clk);
      if (busy || done) quiet++;
    end
    check("idle_no_activity", quiet, 0);
    @(posedge Clk);
    #1;

    // Full scan without hits.
    run_scan(8'hFF, 1'b0, -1, 0, -1, -1);

    // Hits on (1,4) and (2,7): mask 8'h96, count 2.
    coll_tab[1][4] = 1'b1;
    coll_tab[2][7] = 1'b1;
    run_scan(8'hFF, 1'b0, -1, 0, -1, -1);

    // Consumer holds off the first hit for 5 cycles.
    run_scan(8'hFF, 1'b0, 10, 5, -1, -1);

    // Every pair collides but only slots 0 and 2 are active.
    for (int i = 0; i < N; i++) coll_tab[i] = '1;
    run_scan(8'h05, 1'b0, -1, 0, -1, -1);

    // start mid-scan and start in the DONE cycle are ignored.
    clear_tab();
    coll_tab[1][4] = 1'b1;
    coll_tab[2][7] = 1'b1;
    run_scan(8'hFF, 1'b0, -1, 0, 10, -1);
    run_scan(8'hFF, 1'b0, -1, 0, P + 1, -1);

    // Reset at cycle 15 aborts the scan with no done.
    run_scan(8'hFF, 1'b0, -1, 0, -1, 15);
    quiet = 0;
    repeat (40) begin
      @(negedge Clk);
      if (busy || done) quiet++;
    end
    check("post_abort_idle", quiet, 0);
    @(posedge Clk);
    #1;
    run_scan(8'hFF, 1'b0, -1, 0, -1, -1);

    // Randomized tables, slot masks and consumer back-pressure.
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < N; a++) begin
        for (int b = 0; b < N; b++) coll_tab[a][b] = ($urandom_range(0, 99) < 25);
      end
      run_scan(N'($urandom), r[0], -1, 0, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
